// File: rtl/phy_pkg.sv
// Shared constants for the 4-lane PHY transmit/receive pair: symbols, widths,
// FSM encoding and the per-slot symbol selection rule.
package phy_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;

  localparam logic [BYTE_W-1:0] COM_SYM_DEF = 8'hBC;
  localparam logic [BYTE_W-1:0] IDL_SYM_DEF = 8'h7C;

  typedef enum logic [1:0] {
    RESET  = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } tx_state_e;

  // Invalid lanes send IDL, unless the whole frame is idle, in which case COM
  // keeps the receiver aligned.
  function automatic logic [BYTE_W-1:0] slot_sym(
    input logic [BYTE_W-1:0] data,
    input logic              valid,
    input logic              all_idle,
    input logic [BYTE_W-1:0] com,
    input logic [BYTE_W-1:0] idl
  );
    if (valid) return data;
    return all_idle ? com : idl;
  endfunction

endpackage

// File: rtl/phy_tx_shifter.sv
// MSB-first byte serializer: parallel load on load_i, otherwise shift left
// with zero fill. bit_o comes straight from the shift register flop.
module phy_tx_shifter
  import phy_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic              bit_o,
  output logic [2:0]        bit_cnt_o
);

  logic [BYTE_W-1:0] sr_q, sr_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;

  always_comb begin
    sr_d      = {sr_q[BYTE_W-2:0], 1'b0};
    bit_cnt_d = bit_cnt_q + 3'd1;
    if (load_i) begin
      sr_d      = byte_i;
      bit_cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign bit_o     = sr_q[BYTE_W-1];
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: rtl/phy_tx_serializer.sv
// Transmit PHY stage: COM training burst after reset, then 4-lane byte striping
// serialized MSB-first. Optional PHY_TX_STATS_EN adds a saturating data-slot counter.
module phy_tx_serializer
  import phy_pkg::*;
#(
  parameter int                TRAIN_COMS = 4,
  parameter logic [BYTE_W-1:0] COM_SYM    = COM_SYM_DEF,
  parameter logic [BYTE_W-1:0] IDL_SYM    = IDL_SYM_DEF
) (
  input  logic              clk_32f,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in0,
  input  logic [BYTE_W-1:0] in1,
  input  logic [BYTE_W-1:0] in2,
  input  logic [BYTE_W-1:0] in3,
  input  logic              val_in0,
  input  logic              val_in1,
  input  logic              val_in2,
  input  logic              val_in3,
  output logic              tx_take,
  output logic              salida_tx,
  output logic              tx_active
`ifdef PHY_TX_STATS_EN
  ,
  output logic [15:0]       tx_byte_cnt
`endif
);

  localparam logic [15:0] LAST_FRAME = 16'(TRAIN_COMS / LANES - 1);

  tx_state_e state_q, state_d;
  logic [1:0]  slot_cnt_q, slot_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic [LANES-1:0][BYTE_W-1:0] lane_data;
  logic [LANES-1:0]             lane_val;
  logic [LANES-1:1][BYTE_W-1:0] hold_data_q;
  logic [LANES-1:1]             hold_val_q;
  logic                         hold_idle_q;
  logic [LANES-1:1][BYTE_W-1:0] hold_sym;

  logic              all_idle;
  logic              load;
  logic              frame_end;
  logic              slot_is_data;
  logic [BYTE_W-1:0] slot_byte;
  logic [2:0]        bit_cnt;

  assign lane_data = {in3, in2, in1, in0};
  assign lane_val  = {val_in3, val_in2, val_in1, val_in0};
  assign all_idle  = ~|lane_val;

  for (genvar gi = 1; gi < LANES; gi++) begin : g_hold_sym
    assign hold_sym[gi] = slot_sym(hold_data_q[gi], hold_val_q[gi], hold_idle_q,
                                   COM_SYM, IDL_SYM);
  end

  assign frame_end = (slot_cnt_q == 2'd3) && (bit_cnt == 3'd7);

  always_comb begin
    state_d      = state_q;
    slot_cnt_d   = slot_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    tx_take      = 1'b0;
    load         = 1'b0;
    slot_byte    = COM_SYM;
    slot_is_data = 1'b0;

    unique case (state_q)
      RESET: begin
        load        = 1'b1;
        state_d     = TRAIN;
        slot_cnt_d  = 2'd0;
        frame_cnt_d = '0;
      end
      TRAIN: begin
        load = (bit_cnt == 3'd7);
        if (load) slot_cnt_d = slot_cnt_q + 2'd1;
        // The last training frame hands over with a take so the first
        // ACTIVE frame already carries data.
        if (frame_end) begin
          if (frame_cnt_q == LAST_FRAME) begin
            tx_take = 1'b1;
            state_d = ACTIVE;
          end else begin
            frame_cnt_d = frame_cnt_q + 16'd1;
          end
        end
      end
      ACTIVE: begin
        load = (bit_cnt == 3'd7);
        if (load) slot_cnt_d = slot_cnt_q + 2'd1;
        if (frame_end) begin
          tx_take = 1'b1;
        end else begin
          case (slot_cnt_q)
            2'd0: begin slot_byte = hold_sym[1]; slot_is_data = hold_val_q[1]; end
            2'd1: begin slot_byte = hold_sym[2]; slot_is_data = hold_val_q[2]; end
            2'd2: begin slot_byte = hold_sym[3]; slot_is_data = hold_val_q[3]; end
            default: ;
          endcase
        end
      end
      default: state_d = RESET;
    endcase

    if (tx_take) begin
      slot_byte    = slot_sym(in0, val_in0, all_idle, COM_SYM, IDL_SYM);
      slot_is_data = val_in0;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      state_q     <= RESET;
      slot_cnt_q  <= '0;
      frame_cnt_q <= '0;
      hold_data_q <= '0;
      hold_val_q  <= '0;
      hold_idle_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_cnt_q  <= slot_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (tx_take) begin
        hold_data_q <= lane_data[LANES-1:1];
        hold_val_q  <= lane_val[LANES-1:1];
        hold_idle_q <= all_idle;
      end
    end
  end

  phy_tx_shifter u_shifter (
    .clk_i    (clk_32f),
    .rst_i    (rst),
    .load_i   (load),
    .byte_i   (slot_byte),
    .bit_o    (salida_tx),
    .bit_cnt_o(bit_cnt)
  );

  assign tx_active = (state_q == ACTIVE);

`ifdef PHY_TX_STATS_EN
  logic [15:0] byte_cnt_q;

  always_ff @(posedge clk_32f) begin
    if (rst) begin
      byte_cnt_q <= '0;
    end else if (load && slot_is_data && (byte_cnt_q != 16'hFFFF)) begin
      byte_cnt_q <= byte_cnt_q + 16'd1;
    end
  end

  assign tx_byte_cnt = byte_cnt_q;
`endif

endmodule

// File: tb/tb_phy_tx_serializer.sv
// Bench for phy_tx_serializer: the stream after each reset release is modelled
// as a COM training run followed by 32-bit frame words sent MSB-first.
module tb_phy_tx_serializer;

  localparam int         TRAIN_COMS = 4;
  localparam int         TB_BITS    = TRAIN_COMS * 8;
  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] IDL        = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic       val_in0 = 1'b0, val_in1 = 1'b0, val_in2 = 1'b0, val_in3 = 1'b0;
  logic       tx_take, salida_tx, tx_active;
`ifdef PHY_TX_STATS_EN
  logic [15:0] tx_byte_cnt;
  int          stats_exp;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] exp_frames [$];
  logic [7:0]  com_v    = COM;

  always #5 clk_32f = ~clk_32f;

  phy_tx_serializer #(.TRAIN_COMS(TRAIN_COMS)) dut (
    .clk_32f  (clk_32f),
    .rst      (rst),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .val_in0  (val_in0),
    .val_in1  (val_in1),
    .val_in2  (val_in2),
    .val_in3  (val_in3),
    .tx_take  (tx_take),
    .salida_tx(salida_tx),
    .tx_active(tx_active)
`ifdef PHY_TX_STATS_EN
    ,
    .tx_byte_cnt(tx_byte_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, expv);
    end
  endtask

  // Frame word: slot 0 in the top byte, so the whole word goes out MSB-first.
  function automatic logic [31:0] model_frame(input logic [31:0] d, input logic [3:0] v);
    logic [31:0] r;
    logic [7:0]  sym;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i])          sym = d[8*i +: 8];
      else if (v == 4'h0) sym = COM;
      else               sym = IDL;
      r[31-8*i -: 8] = sym;
    end
    return r;
  endfunction

  task automatic check_reset_outputs();
    check_eq("rst_salida_tx", salida_tx, 1'b0);
    check_eq("rst_tx_active", tx_active, 1'b0);
    check_eq("rst_tx_take", tx_take, 1'b0);
  endtask

  task automatic run_session(input int nframes, input bit directed, input int abort_frame);
    logic [31:0] d, f;
    logic [3:0]  v;
    logic        eb;
    int          k, b;
    exp_frames.delete();
`ifdef PHY_TX_STATS_EN
    stats_exp = 0;
`endif
    rst = 1'b0;
    for (int t = 1; t <= TB_BITS + 32 * nframes; t++) begin
      @(negedge clk_32f);
      cyc = t;
      if (t <= TB_BITS) begin
        eb = com_v[7 - ((t - 1) % 8)];
      end else begin
        k  = (t - TB_BITS - 1) / 32;
        b  = (t - TB_BITS - 1) % 32;
        f  = exp_frames[k];
        eb = f[31 - b];
      end
      check_eq("salida_tx", salida_tx, eb);
      check_eq("tx_take", tx_take, (t >= TB_BITS) && ((t - TB_BITS) % 32 == 0));
      check_eq("tx_active", tx_active, t > TB_BITS);

      if (abort_frame >= 0 && t == TB_BITS + 32 * abort_frame + 13) begin
        rst = 1'b1;
        @(negedge clk_32f);
        cyc = t + 1;
        check_reset_outputs();
        $display("abort: reset pulsed in frame %0d", abort_frame);
        return;
      end

      if (t >= TB_BITS && (t - TB_BITS) % 32 == 0) begin
        k = (t - TB_BITS) / 32;
        d = $urandom();
        v = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom());
        if (directed && k == 0) begin d = 32'hABBA_BDBD; v = 4'hF; end
        if (directed && k == 1) v = 4'h0;
        if (directed && k == 2) begin d[23:16] = 8'h55; v = 4'b1011; end
        if (k == nframes) v = 4'hF;
`ifdef PHY_TX_STATS_EN
        check_eq("tx_byte_cnt", tx_byte_cnt, 32'(stats_exp));
        stats_exp += $countones(v);
`endif
        {in3, in2, in1, in0}             = d;
        {val_in3, val_in2, val_in1, val_in0} = v;
        exp_frames.push_back(model_frame(d, v));
        $display("frame %0d: lanes=%08h valids=%04b expect=%08h", k, d, v, model_frame(d, v));
      end else begin
        {in3, in2, in1, in0}             = $urandom();
        {val_in3, val_in2, val_in1, val_in0} = 4'($urandom());
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk_32f);
    check_reset_outputs();
    run_session(6, 1'b1, 4);
    run_session(8, 1'b0, -1);
`ifdef PHY_TX_STATS_EN
    force dut.byte_cnt_q = 16'hFFFE;
    @(negedge clk_32f);
    release dut.byte_cnt_q;
    repeat (40) @(negedge clk_32f);
    check_eq("tx_byte_cnt_sat", tx_byte_cnt, 32'h0000_FFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
